// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: shares the single-ported text/data RAM between instruction fetch and
// load/store, decoding the memory map and arbitrating round-robin with a one-cycle response.
module rv_mem_arbiter #(
  parameter logic [31:0] TEXT_BEGIN = 32'h00400000,
  parameter int          TEXT_BITS  = 16,
  parameter logic [31:0] DATA_BEGIN = 32'h80000000,
  parameter int          DATA_BITS  = 17
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [31:0]          i_rdata,
  output logic                 i_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [3:0]           d_be,
  input  logic [31:0]          d_addr,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  output logic                 d_err,
  output logic                 mem_en,
  output logic                 mem_sel,
  output logic                 mem_we,
  output logic [3:0]           mem_be,
  output logic [DATA_BITS-3:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  localparam int AW = DATA_BITS - 2;

  logic [31:0] i_off;
  logic [31:0] d_toff;
  logic [31:0] d_doff;
  logic        i_in_text;
  logic        d_in_text;
  logic        d_in_data;
  logic        i_bad;
  logic        d_bad;
  logic        grant_i;
  logic        grant_d;
  logic        last_data;
  logic        rsp_valid;
  logic        rsp_data;
  logic        rsp_err;
  logic        rsp_write;

  // Unsigned offsets make addresses below a region's base wrap high and fall outside it.
  assign i_off     = i_addr - TEXT_BEGIN;
  assign d_toff    = d_addr - TEXT_BEGIN;
  assign d_doff    = d_addr - DATA_BEGIN;
  assign i_in_text = (i_off >> TEXT_BITS) == 32'd0;
  assign d_in_text = (d_toff >> TEXT_BITS) == 32'd0;
  assign d_in_data = (d_doff >> DATA_BITS) == 32'd0;

  assign i_bad = (i_addr[1:0] != 2'b00) | ~i_in_text;
  assign d_bad = (d_addr[1:0] != 2'b00) | (~d_in_text & ~d_in_data)
               | (d_we & d_in_text) | (d_we & (d_be == 4'b0000));

  // A tie goes to whichever port did not win last time.
  assign grant_i = ~reset & i_req & (~d_req | last_data);
  assign grant_d = ~reset & d_req & ~grant_i;
  assign i_gnt   = grant_i;
  assign d_gnt   = grant_d;

  // Winner drives the RAM; an error grant still takes the slot but leaves the RAM idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = {AW{1'b0}};
    mem_wdata = 32'h0000_0000;
    if (grant_i) begin
      mem_en   = ~i_bad;
      mem_be   = 4'b1111;
      mem_addr = AW'(i_off[TEXT_BITS-1:2]);
    end else if (grant_d) begin
      mem_en    = ~d_bad;
      mem_sel   = ~d_in_text;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_in_text ? AW'(d_toff[TEXT_BITS-1:2]) : d_doff[DATA_BITS-1:2];
      mem_wdata = d_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Response bookkeeping and last-grant pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_data <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_write <= 1'b0;
    end else begin
      rsp_valid <= grant_i | grant_d;
      rsp_data  <= grant_d;
      rsp_err   <= grant_i ? i_bad : d_bad;
      rsp_write <= grant_d & d_we;
      if (grant_i | grant_d) begin
        last_data <= grant_d;
      end
    end
  end

  // Responses are masked during reset so a pending one is dropped.
  assign i_rvalid = rsp_valid & ~rsp_data & ~reset;
  assign d_rvalid = rsp_valid & rsp_data & ~reset;
  assign i_err    = i_rvalid & rsp_err;
  assign d_err    = d_rvalid & rsp_err;
  assign i_rdata  = (i_rvalid & ~rsp_err) ? mem_rdata : 32'h0000_0000;
  assign d_rdata  = (d_rvalid & ~rsp_err & ~rsp_write) ? mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Randomised scoreboard bench for rv_mem_arbiter: a byte-address reference model predicts
// grants, RAM strobes and responses; a separate monitor checks responses when due.
module tb_rv_mem_arbiter;

  localparam logic [31:0] TB_BASE = 32'h00400000;
  localparam logic [31:0] DB_BASE = 32'h80000000;
  localparam int          TBITS   = 16;
  localparam int          DBITS   = 17;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr = 32'h0, i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0, d_rdata;
  logic        mem_en, mem_sel, mem_we;
  logic [3:0]  mem_be;
  logic [DBITS-3:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clock = ~clock;

  rv_mem_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_sel(mem_sel), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        port;   // 0 = fetch, 1 = data
    logic        err;
    logic [31:0] rdata;
    logic [31:0] due;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] ram [int];
  logic [31:0] ref_mem [logic [31:0]];

  // Pending requests held by the requesters until granted.
  logic        p_ireq = 1'b0, p_dreq = 1'b0, p_dwe = 1'b0;
  logic [31:0] p_iaddr = 32'h0, p_daddr = 32'h0, p_dwdata = 32'h0;
  logic [3:0]  p_dbe = 4'h0;
  logic        want_reset = 1'b1;
  logic        m_last_d = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic sel, input logic [31:0] idx);
    return (sel ? 32'hDA7A0000 : 32'h7E470000) ^ (idx * 32'h00010001) ^ 32'h00005A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit in_text(input logic [31:0] a);
    logic [31:0] o;
    o = a - TB_BASE;
    return o < (32'd1 << TBITS);
  endfunction

  function automatic bit in_data(input logic [31:0] a);
    logic [31:0] o;
    o = a - DB_BASE;
    return o < (32'd1 << DBITS);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    if (in_text(a)) return init_word(1'b0, (a - TB_BASE) >> 2);
    return init_word(1'b1, (a - DB_BASE) >> 2);
  endfunction

  function automatic logic [31:0] ram_rd(input logic sel, input logic [31:0] idx);
    int k;
    k = int'(idx) + (sel ? 1048576 : 0);
    if (ram.exists(k)) return ram[k];
    return init_word(sel, idx);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] edges [6];
    edges = '{32'h0040FFFC, 32'h00410000, 32'h8001FFFC, 32'h80020000, 32'hFFFFFFFC, 32'h003FFFFC};
    case ($urandom_range(9))
      0, 1, 2, 3: return TB_BASE + (32'($urandom_range(63)) << 2);
      4, 5, 6:    return DB_BASE + (32'($urandom_range(63)) << 2);
      7:          return edges[$urandom_range(5)];
      8:          return TB_BASE + 32'($urandom_range(255));
      default:    return $urandom();
    endcase
  endfunction

  always @(posedge clock) cyc <= cyc + 32'd1;

  // Single-ported RAM with one-cycle read latency.
  initial begin
    forever begin
      @(posedge clock);
      if (mem_en) begin
        if (mem_we) ram[int'(mem_addr) + (mem_sel ? 1048576 : 0)] = merge(ram_rd(mem_sel, 32'(mem_addr)), mem_wdata, mem_be);
        else mem_rdata <= ram_rd(mem_sel, 32'(mem_addr));
      end
    end
  end

  // Monitor: compares the response due this cycle, or demands silence.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("i_rvalid_in_reset", 32'(i_rvalid), 32'd0);
        chk("d_rvalid_in_reset", 32'(d_rvalid), 32'd0);
      end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("i_rvalid", 32'(i_rvalid), 32'(!e.port));
        chk("d_rvalid", 32'(d_rvalid), 32'(e.port));
        if (e.port) begin
          chk("d_err", 32'(d_err), 32'(e.err));
          chk("d_rdata", d_rdata, e.rdata);
          chk("i_rdata_idle", i_rdata, 32'd0);
        end else begin
          chk("i_err", 32'(i_err), 32'(e.err));
          chk("i_rdata", i_rdata, e.rdata);
          chk("d_rdata_idle", d_rdata, 32'd0);
        end
      end else begin
        chk("spurious_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("spurious_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("idle_i_rdata", i_rdata, 32'd0);
        chk("idle_d_rdata", d_rdata, 32'd0);
      end
    end
  end

  // One clock of stimulus plus prediction of grant, RAM strobe and response.
  task automatic step();
    logic gi, gd, bad, ds;
    logic [31:0] a, off;
    exp_t e;
    @(posedge clock);
    #1;
    reset   = want_reset;
    i_req   = p_ireq;  i_addr = p_iaddr;
    d_req   = p_dreq;  d_we = p_dwe; d_be = p_dbe; d_addr = p_daddr; d_wdata = p_dwdata;
    #1;
    if (reset) begin
      chk("i_gnt_in_reset", 32'(i_gnt), 32'd0);
      chk("d_gnt_in_reset", 32'(d_gnt), 32'd0);
      chk("mem_en_in_reset", 32'(mem_en), 32'd0);
      exp_q.delete();
      m_last_d = 1'b1;
      return;
    end
    gi = p_ireq && (!p_dreq || m_last_d);
    gd = p_dreq && !gi;
    chk("i_gnt", 32'(i_gnt), 32'(gi));
    chk("d_gnt", 32'(d_gnt), 32'(gd));
    if (gi || gd) begin
      m_last_d = gd;
      a = gi ? p_iaddr : p_daddr;
      if (gi) bad = (a[1:0] != 2'b00) || !in_text(a);
      else    bad = (a[1:0] != 2'b00) || (!in_text(a) && !in_data(a)) || (p_dwe && (in_text(a) || p_dbe == 4'h0));
      e.port  = gd;
      e.err   = bad;
      e.rdata = 32'd0;
      e.due   = cyc + 32'd1;
      chk("mem_en", 32'(mem_en), 32'(!bad));
      if (!bad) begin
        ds  = gd && !in_text(a);
        off = a - (ds ? DB_BASE : TB_BASE);
        chk("mem_sel", 32'(mem_sel), 32'(ds));
        chk("mem_addr", 32'(mem_addr), off >> 2);
        chk("mem_we", 32'(mem_we), 32'(gd && p_dwe));
        if (gd && p_dwe) begin
          chk("mem_be", 32'(mem_be), 32'(p_dbe));
          chk("mem_wdata", mem_wdata, p_dwdata);
          ref_mem[a] = merge(ref_rd(a), p_dwdata, p_dbe);
        end else begin
          if (gi) chk("mem_be_fetch", 32'(mem_be), 32'h0000000F);
          e.rdata = ref_rd(a);
        end
      end
      exp_q.push_back(e);
      if (gi) p_ireq = 1'b0;
      else    p_dreq = 1'b0;
    end else begin
      chk("mem_en_idle", 32'(mem_en), 32'd0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && (p_ireq || p_dreq); k++) step();
    chk("grant_timeout", 32'(p_ireq | p_dreq), 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a);
    p_ireq = 1'b1; p_iaddr = a;
    drain();
  endtask

  task automatic dacc(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    p_dreq = 1'b1; p_dwe = we; p_dbe = be; p_daddr = a; p_dwdata = wd;
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a fetch already pending: no grant may leak out.
    want_reset = 1'b1;
    p_ireq = 1'b1; p_iaddr = TB_BASE;
    step(); step();
    want_reset = 1'b0;

    // Both ports busy from reset: fetch first, then strict alternation.
    for (int n = 0; n < 8; n++) begin
      p_ireq = 1'b1; p_iaddr = TB_BASE;
      p_dreq = 1'b1; p_dwe = 1'b0; p_dbe = 4'hF; p_daddr = DB_BASE + 32'd8;
      step();
    end
    drain();

    fetch(32'h00400010);
    dacc(1'b1, 4'b0011, 32'h80000004, 32'hDEADBEEF);
    dacc(1'b0, 4'b1111, 32'h80000004, 32'h0);
    fetch(32'h80000000);
    dacc(1'b1, 4'b1111, 32'h00400000, 32'h12345678);
    dacc(1'b0, 4'b1111, 32'h00410000, 32'h0);
    fetch(32'h00400002);
    dacc(1'b0, 4'b1111, 32'h8001FFFC, 32'h0);
    dacc(1'b0, 4'b1111, 32'h80020000, 32'h0);
    fetch(32'h0040FFFC);
    fetch(32'h00410000);
    dacc(1'b0, 4'b1111, 32'hFFFFFFFC, 32'h0);
    dacc(1'b1, 4'b0000, 32'h80000010, 32'hCAFEF00D);
    dacc(1'b0, 4'b1111, 32'h00400040, 32'h0);

    // Random traffic with holds, occasional cancellations and simultaneous requests.
    for (int n = 0; n < 1500; n++) begin
      if (p_ireq && $urandom_range(15) == 0) p_ireq = 1'b0;
      if (p_dreq && $urandom_range(15) == 0) p_dreq = 1'b0;
      if (!p_ireq && $urandom_range(2) != 0) begin
        p_ireq = 1'b1; p_iaddr = rand_addr();
      end
      if (!p_dreq && $urandom_range(2) != 0) begin
        p_dreq = 1'b1; p_dwe = 1'($urandom_range(1)); p_dbe = 4'($urandom_range(15));
        p_daddr = rand_addr(); p_dwdata = $urandom();
      end
      step();
    end
    p_ireq = 1'b0; p_dreq = 1'b0;
    step();

    // Reset right after a grant drops its response; a tie afterwards goes to fetch.
    fetch(32'h00400020);
    want_reset = 1'b1;
    p_ireq = 1'b1; p_iaddr = TB_BASE + 32'd4;
    p_dreq = 1'b1; p_dwe = 1'b0; p_dbe = 4'hF; p_daddr = DB_BASE;
    step(); step();
    want_reset = 1'b0;
    step();
    chk("tie_after_reset_fetch_first", 32'(p_dreq), 32'd1);
    drain();
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
